// File: rtl/d_mem.sv
// -----------------------------------------------------------------------------
// d_mem -- data memory for a single-issue core.
//
// A DEPTH x 32-bit word array, addressed by byte. It is little-endian, stores
// happen in one cycle, and loads return one cycle after the request.
// After reset the array is swept to zero at one word per cycle. busy is high
// during the sweep, and every request made while busy is high is ignored.
//
// Configuration macro: DMEM_SUBWORD_EN
//   defined   : byte/half accesses (size, unsigned_ld honoured; sub-word
//               alignment rules apply)
//   undefined : every access is word-wide; size and unsigned_ld are ignored;
//               only address[1:0] != 00 is misaligned
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 4..4096)
//
// Ports
//   clock        single clock, all state updates on the rising edge
//   reset        synchronous, active-high; restarts the clear sweep
//   address      byte address (word index = address[log2(DEPTH)+1:2])
//   write_data   store data (byte: [7:0], half: [15:0], word: [31:0])
//   mem_read     load request
//   mem_write    store request (takes priority: a read+write is a store only)
//   size         00 byte, 01 half, 10/11 word
//   unsigned_ld  1 zero-extends, 0 sign-extends byte/half loads
//   read_data    registered load result, held between loads
//   read_valid   one-cycle pulse qualifying read_data
//   misaligned   one-cycle pulse flagging a rejected access
//   busy         high while the clear sweep runs
// -----------------------------------------------------------------------------
module d_mem #(
    parameter int DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        misaligned,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]   mem [DEPTH];
    logic [0:0]    state;
    logic [AW-1:0] sweep_idx;

    // -------------------------------------------------------------------------
    // Address decode and lane handling
    // -------------------------------------------------------------------------
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic [31:0]   cur_word;
    logic [31:0]   shifted;
    logic          is_misaligned;
    logic [3:0]    byte_en;
    logic [31:0]   store_word;
    logic [31:0]   load_word;
    logic          access_req;
    logic          do_store;
    logic          do_load;

    // Higher address bits are dropped, so accesses wrap modulo DEPTH*4 bytes.
    assign word_idx = address[AW+1:2];
    assign lane     = address[1:0];
    assign cur_word = mem[word_idx];

    // Bring the addressed lane down to bit 0. For an aligned half, lane[0]
    // is zero, so the same shift also selects the correct half.
    assign shifted  = cur_word >> {lane, 3'b000};

`ifdef DMEM_SUBWORD_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        unused_addr_hi;

    assign ld_byte        = shifted[7:0];
    assign ld_half        = shifted[15:0];
    assign unused_addr_hi = ^address[31:AW+2];

    // NOTE: every output of a combinational block is given a default first.
    // Without it, a path through the case that skips an assignment infers a
    // latch.
    always_comb begin
        is_misaligned = 1'b0;
        byte_en       = 4'b1111;
        store_word    = write_data;
        load_word     = cur_word;
        case (size)
            2'b00: begin
                byte_en    = 4'b0001 << lane;
                store_word = {4{write_data[7:0]}};
                load_word  = unsigned_ld ? {24'h0, ld_byte}
                                         : {{24{ld_byte[7]}}, ld_byte};
            end
            2'b01: begin
                is_misaligned = lane[0];
                byte_en       = lane[1] ? 4'b1100 : 4'b0011;
                store_word    = {2{write_data[15:0]}};
                load_word     = unsigned_ld ? {16'h0, ld_half}
                                            : {{16{ld_half[15]}}, ld_half};
            end
            default: begin
                // 10 and 11 are both full-word accesses.
                is_misaligned = (lane != 2'b00);
            end
        endcase
    end
`else
    logic unused_cfg;

    // Word-only build: size and unsigned_ld have no effect.
    assign unused_cfg    = ^{address[31:AW+2], size, unsigned_ld, shifted};
    assign is_misaligned = (lane != 2'b00);
    assign byte_en       = 4'b1111;
    assign store_word    = write_data;
    assign load_word     = cur_word;
`endif

    // busy comes straight from the state register. This keeps it glitch-free,
    // and it falls on the same edge that writes the last sweep word.
    assign busy       = (state == ST_CLEAR);
    assign access_req = (mem_read | mem_write) & ~busy;
    assign do_store   = access_req & mem_write & ~is_misaligned & ~reset;
    assign do_load    = access_req & mem_read & ~mem_write & ~is_misaligned;

    // -------------------------------------------------------------------------
    // Control: FSM, sweep index, registered load port
    // -------------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments. Every
    // register then samples values from before the edge, and the order of
    // statements cannot change behaviour.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_CLEAR;
            sweep_idx  <= '0;
            read_data  <= '0;
            read_valid <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            // Both pulses default low. They are raised only for the single
            // cycle that follows an accepted request.
            read_valid <= 1'b0;
            misaligned <= 1'b0;

            case (state)
                ST_CLEAR: begin
                    sweep_idx <= sweep_idx + AW'(1);
                    if (sweep_idx == LAST_IDX) begin
                        state <= ST_READY;
                    end
                end
                default: begin
                    if (access_req && is_misaligned) begin
                        read_data  <= '0;
                        misaligned <= 1'b1;
                    end else if (do_load) begin
                        read_data  <= load_word;
                        read_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Storage: clear sweep and byte-lane stores
    // -------------------------------------------------------------------------
    // NOTE: the array is deliberately left out of the reset branch. A
    // synchronous reset cannot clear every word in one edge without ruining
    // RAM inference. The sweep zeroes the words one at a time, while busy
    // holds off every request.
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) begin
            mem[sweep_idx] <= '0;
        end else if (do_store) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= store_word[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_d_mem.sv
// -----------------------------------------------------------------------------
// tb_d_mem -- self-checking bench for d_mem (DEPTH = 256).
//
// The reference model keeps memory as a flat array of bytes. A store writes
// N consecutive bytes little-endian, and a load gathers N bytes and then
// extends them. The clear sweep is modelled as a countdown of busy cycles.
// A compare process checks every DUT output against the model on each
// falling edge. Directed literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_d_mem;

    localparam int DEPTH = 256;
    localparam int NBYTES = DEPTH * 4;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] read_data;
    logic        read_valid;
    logic        misaligned;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    d_mem #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .size       (size),
        .unsigned_ld(unsigned_ld),
        .read_data  (read_data),
        .read_valid (read_valid),
        .misaligned (misaligned),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    logic [7:0]  m_bytes [NBYTES];
    bit          model_live = 1'b0;
    int          clear_left = 0;
    logic [31:0] exp_rd;
    bit          exp_rv;
    bit          exp_mis;
    bit          exp_busy;

    always @(posedge clock) begin
        int          nb;
        int          ba;
        logic [31:0] v;
        if (reset) begin
            model_live = 1'b1;
            clear_left = DEPTH;
            exp_rd     = '0;
            exp_rv     = 1'b0;
            exp_mis    = 1'b0;
            // Nothing can be accepted until the sweep ends, so the memory can
            // be treated as all-zero straight away.
            foreach (m_bytes[i]) m_bytes[i] = 8'h00;
        end else if (model_live) begin
            exp_rv  = 1'b0;
            exp_mis = 1'b0;
            if (clear_left > 0) begin
                clear_left--;
            end else if (mem_read || mem_write) begin
`ifdef DMEM_SUBWORD_EN
                nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`else
                nb = 4;
`endif
                ba = int'(address % 32'(NBYTES));
                if ((ba % nb) != 0) begin
                    exp_rd  = '0;
                    exp_mis = 1'b1;
                end else if (mem_write) begin
                    for (int i = 0; i < nb; i++) m_bytes[ba + i] = write_data[8*i +: 8];
                end else begin
                    v = '0;
                    for (int i = 0; i < nb; i++) v[8*i +: 8] = m_bytes[ba + i];
`ifdef DMEM_SUBWORD_EN
                    if (nb < 4 && !unsigned_ld && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
`endif
                    exp_rd = v;
                    exp_rv = 1'b1;
                end
            end
        end
        exp_busy = (clear_left > 0);
    end

    // One compare process, checking the outputs away from the active edge.
    always @(negedge clock) begin
        if (model_live) begin
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("read_valid", {31'b0, read_valid}, {31'b0, exp_rv});
            check("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
            check("read_data", read_data, exp_rd);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // -------------------------------------------------------------------------
    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        mem_read    = rd;
        mem_write   = wr;
        size        = sz;
        unsigned_ld = uns;
        address     = a;
        write_data  = wd;
    endtask

    task automatic step(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clock);
        drive(rd, wr, sz, uns, a, wd);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] wd);
        step(1'b0, 1'b1, 2'b10, 1'b0, a, wd);
    endtask

    task automatic lw(input logic [31:0] a);
        step(1'b1, 1'b0, 2'b10, 1'b0, a, 32'h0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    // One-cycle reset; returns on the falling edge just after the reset edge.
    task automatic do_reset();
        @(negedge clock);
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_read_data", read_data, 32'h0);
        check("rst_read_valid", {31'b0, read_valid}, 32'd0);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);
    endtask

    // Counts the busy cycles seen from now on, bounded by 2*DEPTH. If asked,
    // it also fires requests during the sweep and records whether any pulse
    // appeared.
    task automatic count_busy(input bit inject, output int n);
        bit saw_pulse;
        n         = 0;
        saw_pulse = 1'b0;
        while (busy === 1'b1 && n < 2 * DEPTH) begin
            n++;
            if (read_valid !== 1'b0 || misaligned !== 1'b0) saw_pulse = 1'b1;
            if (inject) begin
                case (n)
                    10: drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h1234_5678);
                    11: drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
                    12: drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
                    13: drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
                    default: ;
                endcase
            end
            @(negedge clock);
        end
        if (inject) check("busy_no_pulse", {31'b0, saw_pulse}, 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int          n;
        logic [31:0] a;
        logic [1:0]  sz;
        int          op;

        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

        // Reset then clear, with requests fired mid-sweep.
        do_reset();
        count_busy(1'b1, n);
        check("busy_cycles_first", n, DEPTH);

        // Reset again 100 cycles into a sweep: the count starts over.
        do_reset();
        repeat (100) @(negedge clock);
        do_reset();
        count_busy(1'b0, n);
        check("busy_cycles_restart", n, DEPTH);

        lw(32'h3FC);
        idle();
        check("lw_3fc", read_data, 32'h0);
        check("lw_3fc_valid", {31'b0, read_valid}, 32'd1);
        lw(32'h8);
        idle();
        check("lw_8_store_ignored_while_busy", read_data, 32'h0);

        // Byte store and load.
        sw(32'h10, 32'h1122_3344);
        step(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA);
        step(1'b1, 1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        step(1'b1, 1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
`ifdef DMEM_SUBWORD_EN
        check("lb_12", read_data, 32'hFFFF_FFAA);
`endif
        lw(32'h10);
`ifdef DMEM_SUBWORD_EN
        check("lbu_12", read_data, 32'h0000_00AA);
`endif
        idle();
`ifdef DMEM_SUBWORD_EN
        check("lw_10_after_sb", read_data, 32'h11AA_3344);
`else
        check("lw_10_after_sb", read_data, 32'h1122_3344);
`endif

        // Misaligned word accesses.
        sw(32'h4, 32'h5566_7788);
        lw(32'h6);
        idle();
        check("lw_6_misaligned", {31'b0, misaligned}, 32'd1);
        check("lw_6_valid", {31'b0, read_valid}, 32'd0);
        check("lw_6_data", read_data, 32'h0);
        sw(32'h6, 32'hFFFF_FFFF);
        lw(32'h4);
        idle();
        check("lw_4_unchanged", read_data, 32'h5566_7788);

        // Simultaneous read and write: the store wins, and the store is
        // visible on the next cycle.
        step(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
        lw(32'h20);
        check("rw_no_valid", {31'b0, read_valid}, 32'd0);
        idle();
        check("lw_20", read_data, 32'hDEAD_BEEF);
        check("lw_20_valid", {31'b0, read_valid}, 32'd1);

        // Address wrap, then read_data held while idle.
        sw(32'h400, 32'hCAFE_F00D);
        lw(32'h0);
        idle();
        check("lw_0_wrap", read_data, 32'hCAFE_F00D);
        idle();
        check("hold_data", read_data, 32'hCAFE_F00D);
        check("hold_valid", {31'b0, read_valid}, 32'd0);

        // Randomized traffic over a small window, with random high bits.
        for (int i = 0; i < 3000; i++) begin
            op = int'($urandom_range(0, 5));
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                a = a & ((sz == 2'b00) ? 32'hFFFF_FFFF : (sz == 2'b01) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
            end
            case (op)
                0, 1: step(1'b1, 1'b0, sz, 1'($urandom), a, 32'h0);
                2, 3: step(1'b0, 1'b1, sz, 1'b0, a, $urandom);
                4:    step(1'b1, 1'b1, sz, 1'b0, a, $urandom);
                default: idle();
            endcase
        end

        // Reset in the middle of operation: read_data clears and the sweep
        // reruns in full.
        lw(32'h0);
        idle();
        do_reset();
        count_busy(1'b0, n);
        check("busy_cycles_midop", n, DEPTH);
        lw(32'h0);
        idle();
        check("lw_0_after_clear", read_data, 32'h0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
